// File: rtl/dual_retire_queue.sv
// Dual-issue ALU result queue: enqueues up to two results per cycle in program
// order, retires one per cycle to the register file and offers a bypass lookup.
module dual_retire_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_0,
  input  logic [4:0]                 in_rd_0,
  input  logic [XLEN-1:0]            in_result_0,
  input  logic                       in_valid_1,
  input  logic [4:0]                 in_rd_1,
  input  logic [XLEN-1:0]            in_result_1,
  output logic                       in_ready,
  output logic                       wb_en,
  output logic [4:0]                 wb_rd,
  output logic [XLEN-1:0]            wb_data,
  input  logic [4:0]                 q_rs,
  output logic                       q_hit,
  output logic [XLEN-1:0]            q_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [31:0]                retired_total,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [4:0]      rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_next;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   slot1_idx;
  logic            push0;
  logic            push1;
  logic            pop;
  logic            lost;

  // Readiness looks only at registered occupancy so there is no path from in_valid_*.
  assign in_ready  = (count <= CW'(DEPTH - 2));
  assign push0     = !rst && in_valid_0 && in_ready && (in_rd_0 != 5'd0);
  assign push1     = !rst && in_valid_1 && in_ready && (in_rd_1 != 5'd0);
  assign pop       = (count != '0);
  assign lost      = !in_ready && ((in_valid_0 && (in_rd_0 != 5'd0)) ||
                                   (in_valid_1 && (in_rd_1 != 5'd0)));
  // Slot 1 follows slot 0 only when slot 0 actually enqueued.
  assign slot1_idx = tail + AW'(push0);

  always_comb begin
    valid_next = valid_q;
    if (pop)   valid_next[head]      = 1'b0;
    if (push0) valid_next[tail]      = 1'b1;
    if (push1) valid_next[slot1_idx] = 1'b1;
  end

  // Payload storage; validity lives in valid_q so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push0) begin
      rd_q[tail]   <= in_rd_0;
      data_q[tail] <= in_result_0;
    end
    if (push1) begin
      rd_q[slot1_idx]   <= in_rd_1;
      data_q[slot1_idx] <= in_result_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      valid_q       <= '0;
      wb_en         <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      retired_total <= '0;
      overflow      <= 1'b0;
    end else begin
      wb_en   <= pop;
      if (pop) begin
        wb_rd         <= rd_q[head];
        wb_data       <= data_q[head];
        head          <= head + AW'(1);
        retired_total <= retired_total + 32'd1;
      end
      tail    <= tail + AW'(push0) + AW'(push1);
      count   <= count + CW'(push0) + CW'(push1) - CW'(pop);
      valid_q <= valid_next;
      if (lost) overflow <= 1'b1;
    end
  end

  // Walk from head toward tail so the youngest match wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[head + AW'(i)] && (rd_q[head + AW'(i)] == q_rs) && (q_rs != 5'd0)) begin
        q_hit  = 1'b1;
        q_data = data_q[head + AW'(i)];
      end
    end
  end

endmodule

// File: doc/dual_retire_queue.md
DUAL_RETIRE_QUEUE -- requirements
Module: dual_retire_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving queue entries; it must be a power of 2 and at least 4.
REQ-002 The block SHALL have parameter XLEN, default 32, giving the result data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid_0  input  1  slot-0 (older) ALU result valid.
REQ-006 in_rd_0  input  5  slot-0 destination register.
REQ-007 in_result_0  input  XLEN  slot-0 result.
REQ-008 in_valid_1  input  1  slot-1 (younger) ALU result valid.
REQ-009 in_rd_1  input  5  slot-1 destination register.
REQ-010 in_result_1  input  XLEN  slot-1 result.
REQ-011 in_ready  output  1  queue can accept both slots this cycle.
REQ-012 wb_en  output  1  register-file write strobe (registered).
REQ-013 wb_rd  output  5  write address (registered).
REQ-014 wb_data  output  XLEN  write data (registered).
REQ-015 q_rs  input  5  bypass lookup register.
REQ-016 q_hit  output  1  pending entry for q_rs exists (combinational).
REQ-017 q_data  output  XLEN  youngest pending value for q_rs (combinational).
REQ-018 count  output  log2(DEPTH)+1  occupied entries.
REQ-019 retired_total  output  32  number of writebacks issued.
REQ-020 overflow  output  1  sticky flag: input was lost.

Function
REQ-021 in_ready SHALL equal (DEPTH - count >= 2), derived from registered count only, with no combinational path from in_valid_*.
REQ-022 A slot SHALL be enqueued at the edge when its in_valid is 1, in_ready is 1, and its rd is nonzero.
- A slot with rd == 0 SHALL be discarded silently.
- Discarded rd == 0 slots SHALL not set overflow.
REQ-023 When both slots enqueue, slot 0 SHALL occupy the tail and slot 1 SHALL occupy tail+1, preserving program order.
- Equal nonzero rd values SHALL both be kept.
REQ-024 Pop: at each edge where count (pre-edge) > 0, the head entry SHALL be loaded into wb_rd/wb_data with wb_en=1 and head advanced.
- Otherwise wb_en SHALL be 0, and wb_rd/wb_data SHALL hold their previous values.
REQ-025 Latency: an entry enqueued into an empty queue at edge N SHALL appear with wb_en=1 in the cycle after edge N+1.
- Throughput SHALL be 1 writeback per cycle.
REQ-026 Simultaneous push (0, 1 or 2 entries) and pop at one edge SHALL update count by pushes minus pop.
REQ-027 Head and tail pointers SHALL wrap modulo DEPTH.
- Full/empty SHALL be distinguished by count, never by pointer equality alone.
REQ-028 Any in_valid_x=1 with nonzero rd while in_ready=0 SHALL set overflow.
- The affected data SHALL be dropped, including slot 0 even if space existed for one entry.
- overflow SHALL stay set until reset.
REQ-029 q_hit/q_data SHALL reflect the youngest (closest to tail) valid queue entry whose rd == q_rs.
- Only entries present before the edge count; same-cycle inputs SHALL not be bypassed.
- q_rs == 0 SHALL give q_hit=0.
- q_data SHALL be 0 when q_hit=0.
REQ-030 retired_total SHALL increment by 1 on each edge that sets wb_en=1.
- It SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-031 While rst is 1 at an edge, the block SHALL reset its state.
- count, head, tail, wb_en, wb_rd, wb_data, retired_total and overflow SHALL be cleared to 0.
- All entries SHALL be marked invalid.
- Inputs SHALL be ignored.
REQ-032 Reset asserted mid-operation SHALL discard all pending entries without any writeback.
- in_ready SHALL be 1 in the first cycle after reset.

Verification
REQ-033 After reset, the bench SHALL push (x1,0x11) and (x2,0x22) together.
- Required: wb_en with x1/0x11 one cycle after the push edge, then x2/0x22 the next cycle.
- Required: retired_total=2.
REQ-034 The bench SHALL push (x0,0xAA) and (x5,0x55).
- Required: only x5 is written, and count peaks at 1.
REQ-035 With DEPTH=8, the bench SHALL push 2 entries per cycle for 8 cycles.
- Required: in_ready drops when count >= 7.
- Required: overflow=1 on the first push attempted while in_ready=0.
- Required: the queue drains 1 per cycle in original order, with pointers wrapping.
REQ-036 The bench SHALL push (x3,0x1) then (x3,0x2) and hold q_rs=3.
- Required: q_hit=1 with q_data=0x2 until the second entry retires, then q_hit=0.
REQ-037 The bench SHALL assert rst with 4 entries pending.
- Required: no wb_en afterwards, count=0, overflow=0, in_ready=1.
